// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, WAIT wait states, byte-lane merge/extract
// over an internal doubleword array; misaligned or out-of-range accesses respond with err.
module dmem_responder #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [63:0] BASE       = 64'h0,
   parameter int          WAIT       = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int         DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [3:0] WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        accept, commit;

   logic        lat_we, lat_uns;
   logic [1:0]  lat_size;
   logic [63:0] lat_addr, lat_wdata;

   logic [63:0] mem [DEPTH];

   logic        op_we, op_uns;
   logic [1:0]  op_size;
   logic [63:0] op_addr, op_wdata;
   logic [63:0] dw_full;
   logic [DEPTH_LOG2-1:0] idx;
   logic [2:0]  lane, align_mask;
   logic [3:0]  nbytes;
   logic [7:0]  be;
   logic        misaligned, out_of_range, err;
   logic [63:0] old_word, byte_mask, merged, shifted, ext;

   // With WAIT=0 the commit happens on the accept edge, so operands come straight from the request.
   always_comb begin
      op_we    = (state == S_IDLE) ? req_we       : lat_we;
      op_uns   = (state == S_IDLE) ? req_unsigned : lat_uns;
      op_size  = (state == S_IDLE) ? req_size     : lat_size;
      op_addr  = (state == S_IDLE) ? req_addr     : lat_addr;
      op_wdata = (state == S_IDLE) ? req_wdata    : lat_wdata;
   end

   always_comb begin
      lane    = op_addr[2:0];
      dw_full = (op_addr - BASE) >> 3;
      idx     = dw_full[DEPTH_LOG2-1:0];
      case (op_size)
         2'd0:    align_mask = 3'b000;
         2'd1:    align_mask = 3'b001;
         2'd2:    align_mask = 3'b011;
         default: align_mask = 3'b111;
      endcase
      misaligned   = (lane & align_mask) != 3'd0;
      out_of_range = (op_addr < BASE) || ((dw_full >> DEPTH_LOG2) != 64'd0);
      err          = misaligned || out_of_range;

      old_word = mem[idx];
      nbytes   = 4'd1 << op_size;
      be       = 8'(((9'd1 << nbytes) - 9'd1) << lane);
      for (int i = 0; i < 8; i++) byte_mask[8*i +: 8] = {8{be[i]}};
      merged  = (old_word & ~byte_mask) | ((op_wdata << {lane, 3'b000}) & byte_mask);
      shifted = old_word >> {lane, 3'b000};
      case (op_size)
         2'd0:    ext = op_uns ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
         2'd1:    ext = op_uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
         2'd2:    ext = op_uns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
         default: ext = shifted;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      req_ready = 1'b0;
      accept    = 1'b0;
      commit    = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = !rst;
            accept    = req_valid && !rst;
            if (accept) begin
               if (WAIT > 0) begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = WAIT_INIT;
               end else begin
                  state_nxt = S_RESP;
                  commit    = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt = S_RESP;
               commit    = !rst;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign rsp_valid = (state == S_RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         lat_we    <= 1'b0;
         lat_uns   <= 1'b0;
         lat_size  <= 2'd0;
         lat_addr  <= 64'd0;
         lat_wdata <= 64'd0;
         rsp_rdata <= 64'd0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            lat_we    <= req_we;
            lat_uns   <= req_unsigned;
            lat_size  <= req_size;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
         end
         if (commit) begin
            rsp_rdata <= (err || op_we) ? 64'd0 : ext;
            rsp_err   <= err;
         end else if (state == S_RESP && rsp_ready) begin
            rsp_rdata <= 64'd0;
            rsp_err   <= 1'b0;
         end
      end
   end

   // Array contents survive reset; a store still pending in WAIT never reaches it.
   always_ff @(posedge clk) begin
      if (commit && op_we && !err && !rst) mem[idx] <= merged;
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a WAIT=1 instance, latency and
// backpressure on a WAIT=3 instance, and hand-written reset-during-transaction sequences.
module tb_dmem_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid = 1'b0, req_valid3 = 1'b0;
   logic        req_we = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
   logic        rsp_ready = 1'b0, rsp_ready3 = 1'b0;
   logic        req_ready, rsp_valid, rsp_err;
   logic        req_ready3, rsp_valid3, rsp_err3;
   logic [63:0] rsp_rdata, rsp_rdata3;

   int checks   = 0;
   int failures = 0;

   dmem_responder #(.DEPTH_LOG2(10), .BASE(64'h0), .WAIT(1)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

   dmem_responder #(.DEPTH_LOG2(10), .BASE(64'h0), .WAIT(3)) u_dut3 (
      .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3));

   typedef struct {
      bit          we;
      logic [1:0]  sz;
      bit          uns;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp_rd;
      bit          exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Called just after a negedge; handshake happens on the following posedge.
   task automatic issue(input bit sel, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [63:0] addr, input logic [63:0] wdata);
      req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      if (sel) req_valid3 = 1'b1; else req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_valid3 = 1'b0;
   endtask

   task automatic xact(input bit sel, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [63:0] addr, input logic [63:0] wdata, input int hold,
                       input string name, output logic [63:0] rd, output logic er, output int lat);
      logic [63:0] rd0;
      @(negedge clk);
      chk({name, ":req_ready"}, 64'(sel ? req_ready3 : req_ready), 64'd1);
      chk({name, ":vld_at_hs"}, 64'(sel ? rsp_valid3 : rsp_valid), 64'd0);
      issue(sel, we, sz, uns, addr, wdata);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(sel ? rsp_valid3 : rsp_valid) && lat < 40);
      chk({name, ":rsp_valid"}, 64'(sel ? rsp_valid3 : rsp_valid), 64'd1);
      rd  = sel ? rsp_rdata3 : rsp_rdata;
      er  = sel ? rsp_err3 : rsp_err;
      rd0 = rd;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({name, ":hold_vld"},   64'(sel ? rsp_valid3 : rsp_valid), 64'd1);
         chk({name, ":hold_rdata"}, sel ? rsp_rdata3 : rsp_rdata, rd0);
         chk({name, ":hold_rdy"},   64'(sel ? req_ready3 : req_ready), 64'd0);
      end
      if (sel) rsp_ready3 = 1'b1; else rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready  = 1'b0;
      rsp_ready3 = 1'b0;
      @(negedge clk);
      chk({name, ":idle_vld"},   64'(sel ? rsp_valid3 : rsp_valid), 64'd0);
      chk({name, ":idle_rdata"}, sel ? rsp_rdata3 : rsp_rdata, 64'd0);
      chk({name, ":idle_rdy"},   64'(sel ? req_ready3 : req_ready), 64'd1);
   endtask

   vec_t        vecs[$];
   logic [63:0] rd;
   logic        er;
   int          lat;

   initial begin
      // store B/H/W/D then loads, misaligned and out-of-range cases, last in-range doubleword
      vecs.push_back('{1, 2'd3, 0, 64'h10,   64'h8877665544332211, 64'h0, 0});
      vecs.push_back('{0, 2'd0, 0, 64'h17,   64'h0, 64'hFFFFFFFFFFFFFF88, 0});
      vecs.push_back('{0, 2'd0, 1, 64'h17,   64'h0, 64'h0000000000000088, 0});
      vecs.push_back('{1, 2'd1, 0, 64'h12,   64'h000000000000BEEF, 64'h0, 0});
      vecs.push_back('{0, 2'd3, 0, 64'h10,   64'h0, 64'h88776655BEEF2211, 0});
      vecs.push_back('{0, 2'd1, 0, 64'h12,   64'h0, 64'hFFFFFFFFFFFFBEEF, 0});
      vecs.push_back('{0, 2'd1, 1, 64'h12,   64'h0, 64'h000000000000BEEF, 0});
      vecs.push_back('{0, 2'd2, 0, 64'h14,   64'h0, 64'hFFFFFFFF88776655, 0});
      vecs.push_back('{0, 2'd1, 0, 64'h16,   64'h0, 64'hFFFFFFFFFFFF8877, 0});
      vecs.push_back('{0, 2'd2, 0, 64'h1A,   64'h0, 64'h0, 1});
      vecs.push_back('{1, 2'd3, 0, 64'h1FF8, 64'hA5A5A5A5A5A5A5A5, 64'h0, 0});
      vecs.push_back('{1, 2'd3, 0, 64'h2004, 64'h1234567812345678, 64'h0, 1});
      vecs.push_back('{1, 2'd3, 0, 64'h2000, 64'h1234567812345678, 64'h0, 1});
      vecs.push_back('{0, 2'd3, 0, 64'h2000, 64'h0, 64'h0, 1});
      vecs.push_back('{0, 2'd3, 0, 64'h1FF8, 64'h0, 64'hA5A5A5A5A5A5A5A5, 0});
      vecs.push_back('{0, 2'd0, 1, 64'h1FFF, 64'h0, 64'h00000000000000A5, 0});
      vecs.push_back('{1, 2'd3, 0, 64'h20,   64'h0102030405060708, 64'h0, 0});
      vecs.push_back('{1, 2'd0, 0, 64'h21,   64'hFFFFFFFFFFFFFFAB, 64'h0, 0});
      vecs.push_back('{0, 2'd3, 0, 64'h20,   64'h0, 64'h010203040506AB08, 0});
      vecs.push_back('{0, 2'd0, 0, 64'h21,   64'h0, 64'hFFFFFFFFFFFFFFAB, 0});
      vecs.push_back('{0, 2'd2, 1, 64'h20,   64'h0, 64'h000000000506AB08, 0});
      vecs.push_back('{1, 2'd2, 0, 64'h22,   64'hFFFFFFFFFFFFFFFF, 64'h0, 1});
      vecs.push_back('{0, 2'd3, 0, 64'h20,   64'h0, 64'h010203040506AB08, 0});
      vecs.push_back('{1, 2'd3, 0, 64'h28,   64'h0, 64'h0, 0});

      #1;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_rdata", rsp_rdata, 64'd0);
      chk("rst_rsp_err",   64'(rsp_err), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_req_ready",  64'(req_ready), 64'd1);
      chk("post_rst_req_ready3", 64'(req_ready3), 64'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         xact(1'b0, vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata, 0, nm, rd, er, lat);
         chk({nm, ":rdata"}, rd, vecs[i].exp_rd);
         chk({nm, ":err"},   64'(er), 64'(vecs[i].exp_err));
         chk({nm, ":lat"},   64'(lat), 64'd2);
      end

      // WAIT=3: latency 4, five cycles of backpressure
      xact(1'b1, 1'b1, 2'd3, 1'b0, 64'h40, 64'hDEADBEEF01234567, 0, "w3_store", rd, er, lat);
      chk("w3_store:lat", 64'(lat), 64'd4);
      xact(1'b1, 1'b0, 2'd3, 1'b0, 64'h40, 64'h0, 5, "w3_load", rd, er, lat);
      chk("w3_load:lat",   64'(lat), 64'd4);
      chk("w3_load:rdata", rd, 64'hDEADBEEF01234567);
      chk("w3_load:err",   64'(er), 64'd0);

      // Reset while a store waits: the store is dropped
      @(negedge clk);
      issue(1'b0, 1'b1, 2'd2, 1'b0, 64'h20, 64'h00000000CAFEBABE);
      rst = 1'b1;
      #1;
      chk("rst_wait:req_ready", 64'(req_ready), 64'd0);
      chk("rst_wait:rsp_valid", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      xact(1'b0, 1'b0, 2'd2, 1'b1, 64'h20, 64'h0, 0, "after_rst_wait", rd, er, lat);
      chk("after_rst_wait:rdata", rd, 64'h000000000506AB08);

      // Reset while a load response is held: outputs clear at once
      @(negedge clk);
      issue(1'b0, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
      repeat (2) @(negedge clk);
      chk("rst_resp_load:vld",   64'(rsp_valid), 64'd1);
      chk("rst_resp_load:rdata", rsp_rdata, 64'h88776655BEEF2211);
      rst = 1'b1;
      #1;
      chk("rst_resp_load:vld0",   64'(rsp_valid), 64'd0);
      chk("rst_resp_load:rdata0", rsp_rdata, 64'd0);
      chk("rst_resp_load:rdy0",   64'(req_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Reset while a store response is held: the committed store remains
      @(negedge clk);
      issue(1'b0, 1'b1, 2'd2, 1'b0, 64'h28, 64'h00000000DEADBEEF);
      repeat (2) @(negedge clk);
      chk("rst_resp_store:vld", 64'(rsp_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_resp_store:vld0", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      xact(1'b0, 1'b0, 2'd3, 1'b0, 64'h28, 64'h0, 0, "after_rst_resp", rd, er, lat);
      chk("after_rst_resp:rdata", rd, 64'h00000000DEADBEEF);
      chk("after_rst_resp:err",   64'(er), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the CPU data port (daddr/wdata/ddata plus memrw/memword controls), as the memory-side end of that interface.
- Accepts one load/store request at a time through a valid/ready handshake and inserts a configurable number of wait states.
- Performs little-endian byte/half/word/double lane merging on stores, and lane extraction with sign/zero extension on loads.
- Flags misaligned and out-of-range accesses. Backing store is an internal doubleword array.

Parameters:
- DEPTH_LOG2, 10, log2 of number of 64-bit doublewords in the array (1024 -> 8 KiB)
- BASE, 64'h0, byte address of the first array location
- WAIT, 1, extra wait-state cycles between acceptance and response (0..15)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  64  byte address
- req_wdata  input  64  store data, right-justified (low bytes used)
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts response
- rsp_rdata  output  64  extended load data; 0 for stores and errors
- rsp_err  output  1  access was misaligned or out of range

Behaviour:
- Reset: state IDLE, req_ready=0 while rst high, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE
  - req_ready=1.
  - Handshake on req_valid&&req_ready: latch we/size/unsigned/addr/wdata.
  - Next state is WAIT with counter=WAIT-1 if WAIT>0, else RESP.
- WAIT
  - req_ready=0. Counter decrements each cycle.
  - Leaves to RESP on the cycle counter==0.
- Commit edge: the edge entering RESP.
  - Error check: misaligned when addr[size-1:0]!=0; out-of-range when (addr-BASE)>>3 >= 2^DEPTH_LOG2 or addr<BASE.
  - Store, no error: bytes lane=addr[2:0] .. lane+(1<<size)-1 of word[(addr-BASE)>>3] are replaced by the low bytes of wdata. Other bytes are unchanged.
  - Load, no error: rdata = (word >> 8*addr[2:0]) truncated to 8<<size bits, then sign- or zero-extended to 64. Double ignores req_unsigned.
  - Error: no array write; rdata=0; err=1.
- RESP
  - rsp_valid=1; rdata/err stay stable until the handshake.
  - On rsp_ready: the next cycle is IDLE, rsp_valid=0, rdata=0, err=0.
  - rsp_ready held low keeps the block in RESP indefinitely.
- Latency: accept edge to rsp_valid high = WAIT+1 cycles. With WAIT=0, back-to-back throughput is one request per 2 cycles when rsp_ready is held 1.
- Only one request is outstanding. req_ready is low in WAIT and RESP, so requests presented then are not accepted and must be held by the requester.
- Reset mid-operation:
  - Asserted in WAIT: the pending store is dropped (array unchanged).
  - Asserted in RESP: the already-committed store remains.
  - In both cases the response is discarded.
- Read-after-write: a load accepted after a store response sees the stored data.
- rsp_valid is never asserted in the cycle req_valid&&req_ready fires.
- Inputs in IDLE without req_valid are ignored.

Test Plan:
- Reset, WAIT=1: assert rst mid-cycle -> outputs 0 immediately; after release req_ready=1 next cycle.
- Store double 64'h8877665544332211 @0x10, then load byte @0x17 signed -> rsp_rdata=64'hFFFFFFFFFFFFFF88, err=0. Same load unsigned -> 64'h88.
- Store half 16'hBEEF @0x12 over the previous value, load double @0x10 -> 64'h88776655BEEF2211. Load half @0x12 signed -> 64'hFFFFFFFFFFFFBEEF.
- Misaligned word load @0x1A -> err=1, rdata=0. Store double @0x2004 with DEPTH_LOG2=10 -> err=1 and a following load @0x2000 is also err (out of range); in-range neighbouring words unchanged.
- Latency/backpressure, WAIT=3: request accepted at cycle t -> rsp_valid at t+4. Hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata stable, req_ready=0. Release -> IDLE next cycle.
- Store word 32'hCAFEBABE @0x20, assert rst while in WAIT, release, load word @0x20 -> prior contents returned (store dropped).
